// File: rtl/mmult_sched_pkg.sv
// Shared types for the matrix-multiply job scheduler: command record, FSM states,
// and the command validity helper.
package mmult_sched_pkg;

  localparam int unsigned ADDR_EXT_WIDTH = 64;

  typedef struct packed {
    logic [31:0] a_baseaddr;
    logic [31:0] b_baseaddr;
    logic [31:0] c_baseaddr;
    logic [31:0] a_row;
    logic [31:0] a_col;
    logic [31:0] b_col;
    logic [31:0] work_id;
  } mmult_cmd_t;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StStart,
    StRun
  } sched_state_e;

  // A command with any zero dimension cannot be run by the kernel.
  function automatic logic has_zero_dim(input mmult_cmd_t cmd);
    return (cmd.a_row == 32'd0) || (cmd.a_col == 32'd0) || (cmd.b_col == 32'd0);
  endfunction

endpackage

// File: rtl/mmult_cmd_fifo.sv
// Synchronous command queue for the job scheduler; full/empty derive from the
// registered occupancy so a same-cycle pop never frees a slot for a push.
module mmult_cmd_fifo
  import mmult_sched_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_push,
  input  mmult_cmd_t                           i_data,
  input  logic                                 i_pop,
  output mmult_cmd_t                           o_data,
  output logic                                 o_full,
  output logic                                 o_empty,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]     o_level
);

  localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
  localparam int unsigned LvlW = $clog2(QUEUE_DEPTH + 1);

  mmult_cmd_t      r_mem [QUEUE_DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [LvlW-1:0] r_level;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_level == LvlW'(QUEUE_DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LvlW'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LvlW'(1);
      end
    end
  end

endmodule

// File: rtl/mmult_job_scheduler.sv
// Queues parsed commands and runs them one at a time on the mmult kernel via ap_* handshake.
// Optional kernel watchdog enabled by defining MMULT_SCHED_WDOG_EN.
module mmult_job_scheduler
  import mmult_sched_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned WDOG_CYCLES = 2**24
) (
  input  logic                                axis_aclk,
  input  logic                                axis_rstn,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic [31:0]                         cmd_a_baseaddr,
  input  logic [31:0]                         cmd_b_baseaddr,
  input  logic [31:0]                         cmd_c_baseaddr,
  input  logic [31:0]                         cmd_a_row,
  input  logic [31:0]                         cmd_a_col,
  input  logic [31:0]                         cmd_b_col,
  input  logic [31:0]                         cmd_work_id,
  output logic [ADDR_EXT_WIDTH-1:0]           ker_a,
  output logic [ADDR_EXT_WIDTH-1:0]           ker_b,
  output logic [ADDR_EXT_WIDTH-1:0]           ker_c,
  output logic [31:0]                         ker_a_row,
  output logic [31:0]                         ker_a_col,
  output logic [31:0]                         ker_b_col,
  output logic [31:0]                         ker_work_id,
  output logic                                ker_param_vld,
  output logic                                ap_start,
  input  logic                                ap_ready,
  input  logic                                ap_done,
  input  logic                                ap_idle,
  output logic                                err_vld,
  output logic [31:0]                         err_work_id,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]    queue_level,
  output logic                                sched_busy,
  output logic [CNT_WIDTH-1:0]                jobs_done,
  output logic                                wdog_timeout,
  input  logic                                wdog_clr
);

  sched_state_e         r_state;
  sched_state_e         w_state_nxt;
  mmult_cmd_t           w_cmd_in;
  mmult_cmd_t           w_head;
  mmult_cmd_t           r_ker;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_pop;
  logic                 w_reject;
  logic                 w_dispatch;
  logic                 w_job_done;
  logic                 r_err_vld;
  logic [31:0]          r_err_work_id;
  logic [CNT_WIDTH-1:0] r_jobs_done;

  assign w_cmd_in = '{a_baseaddr: cmd_a_baseaddr, b_baseaddr: cmd_b_baseaddr,
                      c_baseaddr: cmd_c_baseaddr, a_row: cmd_a_row, a_col: cmd_a_col,
                      b_col: cmd_b_col, work_id: cmd_work_id};

  mmult_cmd_fifo #(
    .QUEUE_DEPTH(QUEUE_DEPTH)
  ) u_cmd_fifo (
    .i_clk   (axis_aclk),
    .i_rst_n (axis_rstn),
    .i_push  (cmd_valid),
    .i_data  (w_cmd_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (queue_level)
  );

  assign cmd_ready  = !w_full;
  assign w_pop      = (r_state == StIdle) && !w_empty && ap_idle;
  assign w_reject   = w_pop && has_zero_dim(w_head);
  assign w_dispatch = w_pop && !has_zero_dim(w_head);

  always_comb begin
    w_state_nxt   = r_state;
    ker_param_vld = 1'b0;
    ap_start      = 1'b0;
    sched_busy    = 1'b1;
    w_job_done    = 1'b0;
    unique case (r_state)
      StIdle: begin
        sched_busy = 1'b0;
        if (w_dispatch) begin
          w_state_nxt = StLoad;
        end
      end
      StLoad: begin
        ker_param_vld = 1'b1;
        w_state_nxt   = StStart;
      end
      StStart: begin
        ap_start = 1'b1;
        if (ap_ready) begin
          w_job_done  = ap_done;
          w_state_nxt = ap_done ? StIdle : StRun;
        end
      end
      StRun: begin
        if (ap_done) begin
          w_job_done  = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge axis_aclk or negedge axis_rstn) begin
    if (!axis_rstn) begin
      r_state       <= StIdle;
      r_ker         <= '0;
      r_err_vld     <= 1'b0;
      r_err_work_id <= '0;
      r_jobs_done   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_err_vld <= w_reject;
      if (w_dispatch) begin
        r_ker <= w_head;
      end
      if (w_reject) begin
        r_err_work_id <= w_head.work_id;
      end
      if (w_job_done) begin
        r_jobs_done <= r_jobs_done + CNT_WIDTH'(1);
      end
    end
  end

  assign ker_a       = ADDR_EXT_WIDTH'(r_ker.a_baseaddr);
  assign ker_b       = ADDR_EXT_WIDTH'(r_ker.b_baseaddr);
  assign ker_c       = ADDR_EXT_WIDTH'(r_ker.c_baseaddr);
  assign ker_a_row   = r_ker.a_row;
  assign ker_a_col   = r_ker.a_col;
  assign ker_b_col   = r_ker.b_col;
  assign ker_work_id = r_ker.work_id;
  assign err_vld     = r_err_vld;
  assign err_work_id = r_err_work_id;
  assign jobs_done   = r_jobs_done;

`ifdef MMULT_SCHED_WDOG_EN
  localparam int unsigned WdogW = $clog2(WDOG_CYCLES + 1);

  logic [WdogW-1:0] r_wdog_cnt;
  logic             r_wdog_timeout;
  logic             w_wdog_active;
  logic             w_wdog_hit;

  assign w_wdog_active = (r_state == StStart) || (r_state == StRun);
  assign w_wdog_hit    = w_wdog_active && (r_wdog_cnt == WdogW'(WDOG_CYCLES - 1));

  // Counter saturates at the limit so the hit fires once per job and a clear sticks.
  always_ff @(posedge axis_aclk or negedge axis_rstn) begin
    if (!axis_rstn) begin
      r_wdog_cnt     <= '0;
      r_wdog_timeout <= 1'b0;
    end else begin
      if (!w_wdog_active) begin
        r_wdog_cnt <= '0;
      end else if (r_wdog_cnt != WdogW'(WDOG_CYCLES)) begin
        r_wdog_cnt <= r_wdog_cnt + WdogW'(1);
      end
      if (w_wdog_hit) begin
        r_wdog_timeout <= 1'b1;
      end else if (wdog_clr) begin
        r_wdog_timeout <= 1'b0;
      end
    end
  end

  assign wdog_timeout = r_wdog_timeout;
`else
  logic w_unused_wdog;
  assign w_unused_wdog = wdog_clr ^ (WDOG_CYCLES == 0);
  assign wdog_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_mmult_job_scheduler.sv
// Directed self-checking bench for mmult_job_scheduler; watchdog steps run only when
// MMULT_SCHED_WDOG_EN is defined.
module tb_mmult_job_scheduler;
  import mmult_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_a_baseaddr = '0, cmd_b_baseaddr = '0, cmd_c_baseaddr = '0;
  logic [31:0] cmd_a_row = '0, cmd_a_col = '0, cmd_b_col = '0, cmd_work_id = '0;
  logic [63:0] ker_a, ker_b, ker_c;
  logic [31:0] ker_a_row, ker_a_col, ker_b_col, ker_work_id;
  logic        ker_param_vld, ap_start;
  logic        ap_ready = 1'b0, ap_done = 1'b0, ap_idle = 1'b1;
  logic        err_vld;
  logic [31:0] err_work_id;
  logic [2:0]  queue_level;
  logic        sched_busy;
  logic [31:0] jobs_done;
  logic        wdog_timeout;
  logic        wdog_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mmult_job_scheduler #(
    .QUEUE_DEPTH(4),
    .CNT_WIDTH  (32),
    .WDOG_CYCLES(100)
  ) dut (
    .axis_aclk     (clk),
    .axis_rstn     (rstn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_a_baseaddr(cmd_a_baseaddr),
    .cmd_b_baseaddr(cmd_b_baseaddr),
    .cmd_c_baseaddr(cmd_c_baseaddr),
    .cmd_a_row     (cmd_a_row),
    .cmd_a_col     (cmd_a_col),
    .cmd_b_col     (cmd_b_col),
    .cmd_work_id   (cmd_work_id),
    .ker_a         (ker_a),
    .ker_b         (ker_b),
    .ker_c         (ker_c),
    .ker_a_row     (ker_a_row),
    .ker_a_col     (ker_a_col),
    .ker_b_col     (ker_b_col),
    .ker_work_id   (ker_work_id),
    .ker_param_vld (ker_param_vld),
    .ap_start      (ap_start),
    .ap_ready      (ap_ready),
    .ap_done       (ap_done),
    .ap_idle       (ap_idle),
    .err_vld       (err_vld),
    .err_work_id   (err_work_id),
    .queue_level   (queue_level),
    .sched_busy    (sched_busy),
    .jobs_done     (jobs_done),
    .wdog_timeout  (wdog_timeout),
    .wdog_clr      (wdog_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [31:0] id, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] row, input logic [31:0] col,
                         input logic [31:0] bcol);
    cmd_work_id    = id;
    cmd_a_baseaddr = a;
    cmd_b_baseaddr = b;
    cmd_c_baseaddr = c;
    cmd_a_row      = row;
    cmd_a_col      = col;
    cmd_b_col      = bcol;
  endtask

  // Standard job: addresses derived from the id, a_row = id.
  task automatic set_std(input logic [31:0] id, input logic [31:0] col);
    set_cmd(id, id << 12, (id << 12) + 32'h100, (id << 12) + 32'h200, id, col, 32'd2);
  endtask

  task automatic wait_start();
    for (int i = 0; i < 30 && ap_start !== 1'b1; i++) step();
    chk("ap_start_seen", {63'd0, ap_start}, 64'd1);
  endtask

  task automatic run_job(input logic [31:0] id, input bit same);
    wait_start();
    chk("job_work_id", {32'd0, ker_work_id}, {32'd0, id});
    chk("job_ker_a", ker_a, {32'd0, id << 12});
    ap_ready = 1'b1;
    ap_done  = same;
    step();
    ap_ready = 1'b0;
    ap_done  = 1'b0;
    if (!same) begin
      chk("run_start_low", {63'd0, ap_start}, 64'd0);
      step();
      ap_done = 1'b1;
      step();
      ap_done = 1'b0;
    end
    chk("job_back_idle", {63'd0, sched_busy}, 64'd0);
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    chk("rst_ker_a", ker_a, 64'd0);
    chk("rst_ker_work_id", {32'd0, ker_work_id}, 64'd0);
    chk("rst_param_vld", {63'd0, ker_param_vld}, 64'd0);
    chk("rst_ap_start", {63'd0, ap_start}, 64'd0);
    chk("rst_err_vld", {63'd0, err_vld}, 64'd0);
    chk("rst_queue_level", {61'd0, queue_level}, 64'd0);
    chk("rst_busy", {63'd0, sched_busy}, 64'd0);
    chk("rst_jobs_done", {32'd0, jobs_done}, 64'd0);
    chk("rst_wdog", {63'd0, wdog_timeout}, 64'd0);
    rstn = 1'b1;
    step();

    // Single job
    set_cmd(32'd7, 32'h1000, 32'h2000, 32'h3000, 32'd4, 32'd4, 32'd4);
    cmd_valid = 1'b1;
    chk("t1_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    step();
    cmd_valid = 1'b0;
    chk("t1_level_1", {61'd0, queue_level}, 64'd1);
    chk("t1_no_vld_yet", {63'd0, ker_param_vld}, 64'd0);
    step();
    chk("t1_param_vld", {63'd0, ker_param_vld}, 64'd1);
    chk("t1_ker_a", ker_a, 64'h1000);
    chk("t1_ker_b", ker_b, 64'h2000);
    chk("t1_ker_c", ker_c, 64'h3000);
    chk("t1_ker_a_row", {32'd0, ker_a_row}, 64'd4);
    chk("t1_ker_work_id", {32'd0, ker_work_id}, 64'd7);
    chk("t1_no_start_in_load", {63'd0, ap_start}, 64'd0);
    chk("t1_level_0", {61'd0, queue_level}, 64'd0);
    step();
    chk("t1_ap_start", {63'd0, ap_start}, 64'd1);
    chk("t1_vld_one_cycle", {63'd0, ker_param_vld}, 64'd0);
    step();
    chk("t1_start_held1", {63'd0, ap_start}, 64'd1);
    step();
    chk("t1_start_held2", {63'd0, ap_start}, 64'd1);
    ap_ready = 1'b1;
    step();
    ap_ready = 1'b0;
    chk("t1_start_dropped", {63'd0, ap_start}, 64'd0);
    chk("t1_busy_run", {63'd0, sched_busy}, 64'd1);
    repeat (9) step();
    ap_done = 1'b1;
    step();
    ap_done = 1'b0;
    chk("t1_jobs_done", {32'd0, jobs_done}, 64'd1);
    chk("t1_idle", {63'd0, sched_busy}, 64'd0);
    chk("t1_ker_a_hold", ker_a, 64'h1000);

    // Five commands into a depth-4 queue with the kernel stalled
    ap_idle   = 1'b0;
    cmd_valid = 1'b1;
    for (int id = 1; id <= 4; id++) begin
      set_std(id, 32'd3);
      step();
    end
    chk("t2_level_full", {61'd0, queue_level}, 64'd4);
    chk("t2_ready_low", {63'd0, cmd_ready}, 64'd0);
    set_std(32'd5, 32'd3);
    step();
    chk("t2_level_still_4", {61'd0, queue_level}, 64'd4);
    chk("t2_no_start_stalled", {63'd0, ap_start}, 64'd0);
    ap_idle = 1'b1;
    step();
    chk("t2_level_after_pop", {61'd0, queue_level}, 64'd3);
    chk("t2_ready_again", {63'd0, cmd_ready}, 64'd1);
    chk("t2_first_vld", {63'd0, ker_param_vld}, 64'd1);
    step();
    cmd_valid = 1'b0;
    chk("t2_level_after_push5", {61'd0, queue_level}, 64'd4);
    for (int id = 1; id <= 5; id++) run_job(id, 1'b0);
    chk("t2_jobs_done", {32'd0, jobs_done}, 64'd6);
    chk("t2_queue_empty", {61'd0, queue_level}, 64'd0);

    // Zero-dimension command is rejected
    set_std(32'h55, 32'd0);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("t3_no_err_yet", {63'd0, err_vld}, 64'd0);
    step();
    chk("t3_err_vld", {63'd0, err_vld}, 64'd1);
    chk("t3_err_work_id", {32'd0, err_work_id}, 64'h55);
    chk("t3_level_0", {61'd0, queue_level}, 64'd0);
    chk("t3_no_load", {63'd0, ker_param_vld}, 64'd0);
    step();
    chk("t3_err_pulse", {63'd0, err_vld}, 64'd0);
    chk("t3_no_start", {63'd0, ap_start}, 64'd0);
    chk("t3_jobs_same", {32'd0, jobs_done}, 64'd6);

    // ap_ready and ap_done together in START
    set_std(32'h21, 32'd1);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    run_job(32'h21, 1'b1);
    chk("t4_jobs_once", {32'd0, jobs_done}, 64'd7);
    ap_done = 1'b1;
    step();
    ap_done = 1'b0;
    step();
    chk("t4_stray_done_ignored", {32'd0, jobs_done}, 64'd7);
    chk("t4_idle", {63'd0, sched_busy}, 64'd0);

    // Reset asserted while running with two jobs queued
    cmd_valid = 1'b1;
    for (int id = 'h31; id <= 'h33; id++) begin
      set_std(id, 32'd1);
      step();
    end
    cmd_valid = 1'b0;
    chk("t5_start", {63'd0, ap_start}, 64'd1);
    ap_ready = 1'b1;
    step();
    ap_ready = 1'b0;
    chk("t5_level_2", {61'd0, queue_level}, 64'd2);
    chk("t5_busy_run", {63'd0, sched_busy}, 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("t5_rst_level", {61'd0, queue_level}, 64'd0);
    chk("t5_rst_start", {63'd0, ap_start}, 64'd0);
    chk("t5_rst_busy", {63'd0, sched_busy}, 64'd0);
    chk("t5_rst_jobs", {32'd0, jobs_done}, 64'd0);
    chk("t5_rst_ker_a", ker_a, 64'd0);
    chk("t5_rst_err_id", {32'd0, err_work_id}, 64'd0);
    chk("t5_rst_ready", {63'd0, cmd_ready}, 64'd1);
    #2;
    rstn = 1'b1;
    step();
    step();
    chk("t5_discarded_no_vld", {63'd0, ker_param_vld}, 64'd0);
    chk("t5_discarded_no_start", {63'd0, ap_start}, 64'd0);

`ifdef MMULT_SCHED_WDOG_EN
    // Watchdog: 100 cycles in START/RUN without ap_done
    set_std(32'h41, 32'd1);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    wait_start();
    ap_ready = 1'b1;
    step();
    ap_ready = 1'b0;
    repeat (98) step();
    chk("t6_wdog_not_yet", {63'd0, wdog_timeout}, 64'd0);
    step();
    chk("t6_wdog_set", {63'd0, wdog_timeout}, 64'd1);
    chk("t6_fsm_unaffected", {63'd0, sched_busy}, 64'd1);
    ap_done = 1'b1;
    step();
    ap_done = 1'b0;
    step();
    chk("t6_wdog_sticky", {63'd0, wdog_timeout}, 64'd1);
    wdog_clr = 1'b1;
    step();
    wdog_clr = 1'b0;
    chk("t6_wdog_cleared", {63'd0, wdog_timeout}, 64'd0);
`else
    wdog_clr = 1'b1;
    step();
    wdog_clr = 1'b0;
    chk("t6_wdog_tied_low", {63'd0, wdog_timeout}, 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
